// File: rtl/adc_spi_slave_mc.sv
// adc_spi_slave_mc
// SPI (mode 0) register slave for the SAR ADC with a tagged result FIFO,
// round-robin channel sequencing under a channel mask, interrupt output and
// sticky overflow reporting.
//
// Ports:
//   clk, reset_        system clock, asynchronous active-low reset
//   cs, sck, mosi      SPI slave inputs (cs active low, sck asynchronous)
//   miso               SPI data out, high-Z while cs is high
//   adc_data_in        conversion result from the SAR
//   adc_busy_in        SAR busy, reported in STATUS[0]
//   adc_eoc_pulse      asynchronous end-of-conversion; rising edge = result valid
//   hw_clear_start     one-cycle pulse from the SAR that clears CTRL[1]
//   ctrl_reg_out       CTRL register
//   adc_ch_sel_out     channel the SAR is converting
//   eoc_flag_out       result FIFO non-empty
//   irq_out            eoc_flag_out & CTRL[3]
//   fifo_level_out     result FIFO occupancy
//
// Frame: {cmd[1:0], addr[2:0], payload[DATA_W-1:0]}, MSB first.
// cmd: 00 READ, 01 WRITE, 10 SET, 11 CLEAR.
// SPI handshake: MOSI is taken on each synchronised sck rise, MISO changes on
// each synchronised sck fall; the frame commits only after FRAME_W rises with
// cs held low, otherwise it is discarded without side effects.
module adc_spi_slave_mc #(
  parameter int                DATA_W     = 12,
  parameter int                NCH        = 4,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [DATA_W-1:0] INFO_ID    = 12'h00B,
  localparam int               CH_W       = $clog2(NCH),
  localparam int               LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              cs,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] adc_data_in,
  input  logic              adc_busy_in,
  input  logic              adc_eoc_pulse,
  input  logic              hw_clear_start,
  output logic [DATA_W-1:0] ctrl_reg_out,
  output logic [CH_W-1:0]   adc_ch_sel_out,
  output logic              eoc_flag_out,
  output logic              irq_out,
  output logic [LVL_W-1:0]  fifo_level_out
);

  localparam int FRAME_W = 5 + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int E_W     = CH_W + DATA_W;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] HDR_BITS = CNT_W'(5);

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_SET   = 2'b10;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_DATA   = 3'd2;
  localparam logic [2:0] A_INFO   = 3'd3;
  localparam logic [2:0] A_CHMASK = 3'd4;
  localparam logic [2:0] A_TAG    = 3'd5;
  localparam logic [2:0] A_LEVEL  = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

  // Lowest set bit of the mask, 0 for an empty mask.
  function automatic logic [CH_W-1:0] lowest_ch(input logic [NCH-1:0] m);
    lowest_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) lowest_ch = CH_W'(i);
  endfunction

  // Next set bit above cur, wrapping; scanning offsets from the far end down
  // makes the nearest one win. A single-bit mask lands back on cur.
  function automatic logic [CH_W-1:0] next_ch(input logic [NCH-1:0] m,
                                              input logic [CH_W-1:0] cur);
    int idx;
    next_ch = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = (int'(cur) + i) % NCH;
      if (m[idx]) next_ch = CH_W'(idx);
    end
  endfunction

  // ---------------------------------------------------------------- sync
  // cs and mosi share the sck synchroniser depth so all three stay aligned.
  logic [1:0] sck_sync, eoc_sync, mosi_sync, cs_sync;
  logic       sck_prev, eoc_prev;
  logic       sck_rise, sck_fall, eoc_rise, cs_s, mosi_s;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sck_sync  <= '0;
      eoc_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= 2'b11;
      sck_prev  <= 1'b0;
      eoc_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      eoc_sync  <= {eoc_sync[0], adc_eoc_pulse};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_sync   <= {cs_sync[0], cs};
      sck_prev  <= sck_sync[1];
      eoc_prev  <= eoc_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign sck_fall = ~sck_sync[1] & sck_prev;
  assign eoc_rise = eoc_sync[1] & ~eoc_prev;
  assign cs_s     = cs_sync[1];
  assign mosi_s   = mosi_sync[1];

  // ---------------------------------------------------------------- FSM
  state_t state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!cs_s) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (cs_s)                                   state_d = ST_IDLE;
        else if (sck_rise && bit_cnt_q == LAST_BIT) state_d = ST_LATCH;
      end
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- shifter
  logic [FRAME_W-1:0] rx_q;
  logic [DATA_W-1:0]  tx_q, rd_val;
  logic               snap_q, preload, latch;
  logic [1:0]         cmd;
  logic [2:0]         addr;
  logic [DATA_W-1:0]  payload;

  // After five rises the header sits in rx_q[4:0]; after FRAME_W rises the
  // whole frame is in rx_q.
  assign preload = (state_q == ST_SHIFT) && sck_fall && (bit_cnt_q == HDR_BITS)
                   && (rx_q[4:3] == CMD_READ);
  assign latch   = (state_q == ST_LATCH);
  assign cmd     = rx_q[FRAME_W-1 -: 2];
  assign addr    = rx_q[DATA_W +: 3];
  assign payload = rx_q[DATA_W-1:0];

  // ---------------------------------------------------------------- regs
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic [NCH-1:0]    mask_q, mask_d;
  logic [CH_W-1:0]   ch_q, ch_d, last_tag_q;
  logic              overflow_q, ctrl_wr, mask_wr, flush;

  // FIFO state
  logic [E_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [E_W-1:0]   head;
  logic             fifo_full, fifo_nonempty, push, pop, ovf_set;

  assign head          = mem[rd_ptr_q];
  assign fifo_full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_nonempty = (level_q != '0);
  assign flush         = ctrl_q[4];
  assign pop           = latch && cmd == CMD_READ && addr == A_DATA && fifo_nonempty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push          = eoc_rise && !flush && (!fifo_full || pop);
  assign ovf_set       = eoc_rise && !flush && fifo_full && !pop;

  always_comb begin
    rd_val = '0;
    case (rx_q[2:0])
      A_CTRL:   rd_val = ctrl_q;
      A_STATUS: rd_val[3:0] = {overflow_q, fifo_full, fifo_nonempty, adc_busy_in};
      A_DATA:   if (fifo_nonempty) rd_val = head[DATA_W-1:0];
      A_INFO:   rd_val = INFO_ID;
      A_CHMASK: rd_val[NCH-1:0] = mask_q;
      A_TAG:    rd_val[CH_W-1:0] = last_tag_q;
      A_LEVEL:  rd_val[LVL_W-1:0] = level_q;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rx_q      <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      snap_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= '0;
          tx_q      <= '0;
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            rx_q      <= {rx_q[FRAME_W-2:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          if (preload) begin
            tx_q   <= rd_val;
            // Only the overflow value actually sent may be cleared later.
            snap_q <= (rx_q[2:0] == A_STATUS) && overflow_q;
          end else if (sck_fall) begin
            tx_q <= {tx_q[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign miso = cs ? 1'bz : tx_q[DATA_W-1];

  assign ctrl_wr = latch && addr == A_CTRL   && cmd != CMD_READ;
  assign mask_wr = latch && addr == A_CHMASK && cmd != CMD_READ;

  always_comb begin
    ctrl_d    = ctrl_q;
    ctrl_d[4] = 1'b0;  // flush lasts exactly one cycle
    if (ctrl_wr) begin
      case (cmd)
        CMD_WRITE: ctrl_d = payload;
        CMD_SET:   ctrl_d = ctrl_q | payload;
        default:   ctrl_d = ctrl_q & ~payload;
      endcase
    end
    if (hw_clear_start) ctrl_d[1] = 1'b0;
  end

  always_comb begin
    mask_d = mask_q;
    if (mask_wr) begin
      case (cmd)
        CMD_WRITE: mask_d = payload[NCH-1:0];
        CMD_SET:   mask_d = mask_q | payload[NCH-1:0];
        default:   mask_d = mask_q & ~payload[NCH-1:0];
      endcase
    end
  end

  always_comb begin
    ch_d = ch_q;
    if (mask_wr)       ch_d = lowest_ch(mask_d);
    else if (eoc_rise) ch_d = next_ch(mask_q, ch_q);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ctrl_q     <= '0;
      mask_q     <= NCH'(1);
      ch_q       <= '0;
      last_tag_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      mask_q <= mask_d;
      ch_q   <= ch_d;
      if (pop) last_tag_q <= head[E_W-1 -: CH_W];
      if (ovf_set)
        overflow_q <= 1'b1;
      else if (latch && cmd == CMD_READ && addr == A_STATUS && snap_q)
        overflow_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {ch_q, adc_data_in};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign ctrl_reg_out   = ctrl_q;
  assign adc_ch_sel_out = ch_q;
  assign eoc_flag_out   = fifo_nonempty;
  assign irq_out        = fifo_nonempty & ctrl_q[3];
  assign fifo_level_out = level_q;

endmodule

// File: tb/tb_adc_spi_slave_mc.sv
// tb_adc_spi_slave_mc
// Self-checking bench for adc_spi_slave_mc: SPI master driver tasks, EOC
// driver, and a reference model (result queue, mask, channel, overflow, CTRL)
// that predicts register reads and output pins.
module tb_adc_spi_slave_mc;

  localparam int DATA_W     = 12;
  localparam int NCH        = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CH_W       = 2;
  localparam int LVL_W      = 4;
  localparam int FRAME_W    = 5 + DATA_W;
  localparam int E_W        = CH_W + DATA_W;
  localparam int H          = 8;  // clk cycles per sck half period

  localparam logic [1:0] C_READ = 2'b00, C_WRITE = 2'b01, C_SET = 2'b10, C_CLEAR = 2'b11;
  localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_DATA = 3'd2, A_INFO = 3'd3;
  localparam logic [2:0] A_CHMASK = 3'd4, A_TAG = 3'd5, A_LEVEL = 3'd6, A_RSVD = 3'd7;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic reset_ = 1'b0;
  logic cs = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic adc_busy_in = 1'b0, adc_eoc_pulse = 1'b0, hw_clear_start = 1'b0;
  logic [DATA_W-1:0] adc_data_in = '0;
  wire               miso;
  logic [DATA_W-1:0] ctrl_reg_out;
  logic [CH_W-1:0]   adc_ch_sel_out;
  logic              eoc_flag_out, irq_out;
  logic [LVL_W-1:0]  fifo_level_out;

  always #5 clk = ~clk;

  adc_spi_slave_mc #(
    .DATA_W(DATA_W), .NCH(NCH), .FIFO_DEPTH(FIFO_DEPTH), .INFO_ID(12'h00B)
  ) dut (
    .clk(clk), .reset_(reset_), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
    .adc_data_in(adc_data_in), .adc_busy_in(adc_busy_in),
    .adc_eoc_pulse(adc_eoc_pulse), .hw_clear_start(hw_clear_start),
    .ctrl_reg_out(ctrl_reg_out), .adc_ch_sel_out(adc_ch_sel_out),
    .eoc_flag_out(eoc_flag_out), .irq_out(irq_out), .fifo_level_out(fifo_level_out)
  );

  // ------------------------------------------------------------ scoreboard
  logic [E_W-1:0]    exp_q[$];
  logic [NCH-1:0]    m_mask;
  int                m_ch;
  bit                m_ovf;
  logic [DATA_W-1:0] m_ctrl;
  int                m_last;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_next(input logic [NCH-1:0] m, input int cur);
    if (m == '0) return 0;
    for (int k = 1; k <= NCH; k++)
      if (m[(cur + k) % NCH]) return (cur + k) % NCH;
    return cur;
  endfunction

  function automatic int model_low(input logic [NCH-1:0] m);
    for (int k = 0; k < NCH; k++)
      if (m[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_mask = NCH'(1);
    m_ch   = 0;
    m_ovf  = 1'b0;
    m_ctrl = '0;
    m_last = 0;
  endtask

  task automatic model_eoc(input logic [DATA_W-1:0] d);
    if (exp_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
    else exp_q.push_back({CH_W'(m_ch), d});
    m_ch = model_next(m_mask, m_ch);
  endtask

  function automatic logic [DATA_W-1:0] model_status();
    logic [DATA_W-1:0] s;
    s = '0;
    s[3] = m_ovf;
    s[2] = (exp_q.size() == FIFO_DEPTH);
    s[1] = (exp_q.size() != 0);
    s[0] = adc_busy_in;
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_level"}, 32'(fifo_level_out), 32'(exp_q.size()));
    check({tag, "_eoc"},   32'(eoc_flag_out), 32'(exp_q.size() != 0));
    check({tag, "_irq"},   32'(irq_out), 32'((exp_q.size() != 0) && m_ctrl[3]));
    check({tag, "_ch"},    32'(adc_ch_sel_out), 32'(m_ch));
    check({tag, "_ctrl"},  32'(ctrl_reg_out), 32'(m_ctrl));
  endtask

  // ------------------------------------------------------------ drivers
  // eoc_at / hwc_at: clk cycles after the last sck rise at which to raise
  // adc_eoc_pulse / hw_clear_start (values <= 0 mean never).
  task automatic spi_frame(input logic [1:0] cmd, input logic [2:0] addr,
                           input logic [DATA_W-1:0] payload, input int nbits,
                           input int eoc_at, input int hwc_at,
                           output logic [DATA_W-1:0] rdata);
    logic [FRAME_W-1:0] f;
    f = {cmd, addr, payload};
    rdata = '0;
    cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = f[FRAME_W-1-i];
      repeat (H) @(negedge clk);
      if (i >= 5) rdata[DATA_W-1-(i-5)] = miso;
      sck = 1'b1;
      for (int c = 1; c <= H; c++) begin
        @(negedge clk);
        if (i == FRAME_W - 1) begin
          if (c == eoc_at)     adc_eoc_pulse = 1'b1;
          if (c == eoc_at + 3) adc_eoc_pulse = 1'b0;
          if (c == hwc_at)     hw_clear_start = 1'b1;
          if (c == hwc_at + 1) hw_clear_start = 1'b0;
        end
      end
      sck = 1'b0;
    end
    repeat (H) @(negedge clk);
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_read(input logic [2:0] addr, output logic [DATA_W-1:0] d);
    spi_frame(C_READ, addr, '0, FRAME_W, -10, -10, d);
  endtask

  task automatic write_reg(input logic [1:0] cmd, input logic [2:0] addr,
                           input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] d;
    spi_frame(cmd, addr, v, FRAME_W, -10, -10, d);
    if (addr == A_CTRL) begin
      case (cmd)
        C_WRITE: m_ctrl = v;
        C_SET:   m_ctrl = m_ctrl | v;
        default: m_ctrl = m_ctrl & ~v;
      endcase
      if (m_ctrl[4]) exp_q.delete();
      m_ctrl[4] = 1'b0;
    end else if (addr == A_CHMASK) begin
      case (cmd)
        C_WRITE: m_mask = v[NCH-1:0];
        C_SET:   m_mask = m_mask | v[NCH-1:0];
        default: m_mask = m_mask & ~v[NCH-1:0];
      endcase
      m_ch = model_low(m_mask);
    end
  endtask

  task automatic do_eoc(input logic [DATA_W-1:0] d);
    adc_data_in = d;
    @(negedge clk);
    adc_eoc_pulse = 1'b1;
    repeat (3) @(negedge clk);
    adc_eoc_pulse = 1'b0;
    repeat (4) @(negedge clk);
    model_eoc(d);
  endtask

  task automatic read_data_chk(input string tag);
    logic [DATA_W-1:0] d;
    logic [E_W-1:0]    e;
    spi_read(A_DATA, d);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, 32'(d), 32'(e[DATA_W-1:0]));
      m_last = int'(e[E_W-1:DATA_W]);
    end else begin
      check(tag, 32'(d), 32'h0);
    end
  endtask

  task automatic read_status_chk(input string tag);
    logic [DATA_W-1:0] d, s;
    adc_busy_in = 1'($urandom_range(0, 1));
    s = model_status();
    spi_read(A_STATUS, d);
    check(tag, 32'(d), 32'(s));
    if (s[3]) m_ovf = 1'b0;
  endtask

  task automatic read_reg_chk(input string tag, input logic [2:0] addr,
                              input logic [DATA_W-1:0] exp);
    logic [DATA_W-1:0] d;
    spi_read(addr, d);
    check(tag, 32'(d), 32'(exp));
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [DATA_W-1:0] d, v;
    logic [E_W-1:0]    e;
    int                op;

    model_reset();
    reset_ = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("rst");
    reset_ = 1'b1;
    repeat (3) @(negedge clk);

    // Identity and idle status
    read_reg_chk("info", A_INFO, 12'h00B);
    adc_busy_in = 1'b0;
    read_reg_chk("status_idle", A_STATUS, 12'h000);
    read_reg_chk("chmask_rst", A_CHMASK, 12'h001);
    read_reg_chk("rsvd", A_RSVD, 12'h000);
    write_reg(C_WRITE, A_RSVD, 12'hFFF);
    read_reg_chk("rsvd_wr", A_RSVD, 12'h000);
    check_outputs("idle");

    // Round-robin over mask 1011 and tagged pops
    write_reg(C_WRITE, A_CHMASK, 12'h00B);
    check_outputs("mask_wr");
    for (int i = 1; i <= 4; i++) begin
      do_eoc(DATA_W'(i * 12'h111));
      check_outputs("rr");
    end
    for (int i = 0; i < 4; i++) begin
      read_data_chk("rr_data");
      read_reg_chk("rr_tag", A_TAG, DATA_W'(m_last));
      check_outputs("rr_pop");
    end

    // Overflow: nine samples into eight entries
    for (int i = 0; i < 9; i++) do_eoc(DATA_W'($urandom_range(0, 4095)));
    check_outputs("ovf");
    read_status_chk("ovf_status");
    read_status_chk("ovf_status_clr");
    for (int i = 0; i < FIFO_DEPTH; i++) read_data_chk("ovf_data");
    check_outputs("ovf_drain");

    // Interrupt, aborted read, full read
    write_reg(C_SET, A_CTRL, 12'h008);
    do_eoc(DATA_W'($urandom_range(0, 4095)));
    check_outputs("irq_set");
    spi_frame(C_READ, A_DATA, '0, 10, -10, -10, d);
    check_outputs("irq_abort");
    read_data_chk("irq_data");
    check_outputs("irq_clr");

    // Push coincident with a pop while full
    for (int i = 0; i < FIFO_DEPTH; i++) do_eoc(DATA_W'($urandom_range(0, 4095)));
    v = DATA_W'($urandom_range(0, 4095));
    adc_data_in = v;
    spi_frame(C_READ, A_DATA, '0, FRAME_W, 1, -10, d);
    e = exp_q.pop_front();
    check("pp_data", 32'(d), 32'(e[DATA_W-1:0]));
    m_last = int'(e[E_W-1:DATA_W]);
    model_eoc(v);
    check_outputs("pp");
    read_status_chk("pp_status");
    for (int i = 0; i < FIFO_DEPTH; i++) read_data_chk("pp_drain");

    // Flush coincident with a push
    for (int i = 0; i < 3; i++) do_eoc(DATA_W'($urandom_range(0, 4095)));
    check_outputs("pre_flush");
    adc_data_in = DATA_W'($urandom_range(0, 4095));
    spi_frame(C_WRITE, A_CTRL, m_ctrl | 12'h010, FRAME_W, 2, -10, d);
    exp_q.delete();
    m_ch = model_next(m_mask, m_ch);
    check_outputs("flush");
    read_data_chk("flush_data");

    // hw_clear_start against an SPI write of CTRL[1]
    spi_frame(C_WRITE, A_CTRL, 12'h00A, FRAME_W, -10, 3, d);
    m_ctrl = 12'h008;
    check_outputs("hwc_latch");
    write_reg(C_SET, A_CTRL, 12'h002);
    check_outputs("start_set");
    hw_clear_start = 1'b1;
    @(negedge clk);
    hw_clear_start = 1'b0;
    @(negedge clk);
    m_ctrl[1] = 1'b0;
    check_outputs("hwc_alone");

    // Random mix
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0, 1: do_eoc(DATA_W'($urandom_range(0, 4095)));
        2:    read_data_chk("rnd_data");
        3:    read_reg_chk("rnd_tag", A_TAG, DATA_W'(m_last));
        4:    read_status_chk("rnd_status");
        default: begin
          v = DATA_W'($urandom_range(0, 15));
          case ($urandom_range(0, 2))
            0:       write_reg(C_WRITE, A_CHMASK, v);
            1:       write_reg(C_SET, A_CHMASK, v);
            default: write_reg(C_CLEAR, A_CHMASK, v);
          endcase
          read_reg_chk("rnd_mask", A_CHMASK, DATA_W'(m_mask));
        end
      endcase
      check_outputs("rnd");
    end

    // Reset in the middle of a frame
    write_reg(C_WRITE, A_CHMASK, 12'h00C);
    write_reg(C_SET, A_CTRL, 12'h00A);
    do_eoc(12'h5A5);
    do_eoc(12'hA5A);
    check_outputs("pre_rst");
    cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset_ = 1'b0;
    #1;
    model_reset();
    check_outputs("mid_rst");
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    reset_ = 1'b1;
    repeat (4) @(negedge clk);
    read_reg_chk("post_rst_mask", A_CHMASK, 12'h001);
    read_reg_chk("post_rst_level", A_LEVEL, 12'h000);
    read_reg_chk("post_rst_tag", A_TAG, 12'h000);
    check_outputs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
